// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, one-entry skid buffer for instructions
// returned during a stall, and the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        IF_ID_Write,
  input  logic        PCSrc,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_s2,
  output logic [31:0] pc4_s2,
  output logic [31:0] inst_s2,
  output logic        valid_s2,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_s2_q, pc_s2_d;
  logic [31:0] pc4_s2_q, pc4_s2_d;
  logic [31:0] inst_s2_q, inst_s2_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_q, skid_d;

  logic        data_avail;
  logic        advance;
  logic [31:0] inst_in;

  assign data_avail = ((state_q == FETCH) && imem_ready) || (state_q == HOLD);
  assign inst_in    = (state_q == HOLD) ? skid_q : imem_rdata;
  assign advance    = data_avail && PCWrite && IF_ID_Write;

  // Gated by rst so the request stays low while reset is held.
  assign imem_req  = rst && (state_q == FETCH);
  assign imem_addr = pc_q;
  assign pc_s2     = pc_s2_q;
  assign pc4_s2    = pc4_s2_q;
  assign inst_s2   = inst_s2_q;
  assign valid_s2  = valid_q;
  assign rs1       = valid_q ? inst_s2_q[19:15] : 5'd0;
  assign rs2       = valid_q ? inst_s2_q[24:20] : 5'd0;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pc_s2_d   = pc_s2_q;
    pc4_s2_d  = pc4_s2_q;
    inst_s2_d = inst_s2_q;
    valid_d   = valid_q;
    skid_d    = skid_q;
    if (PCSrc) begin
      pc_d      = branch_target;
      inst_s2_d = NOP_INST;
      valid_d   = 1'b0;
      skid_d    = '0;
      state_d   = FETCH;
    end else if (advance) begin
      pc_s2_d   = pc_q;
      pc4_s2_d  = pc_q + 32'd4;
      inst_s2_d = inst_in;
      valid_d   = 1'b1;
      pc_d      = pc_q + 32'd4;
      state_d   = FETCH;
    end else if ((state_q == FETCH) && imem_ready) begin
      skid_d  = imem_rdata;
      state_d = HOLD;
    end else if (!data_avail && IF_ID_Write) begin
      inst_s2_d = NOP_INST;
      valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      pc_s2_q   <= '0;
      pc4_s2_q  <= '0;
      inst_s2_q <= NOP_INST;
      valid_q   <= 1'b0;
      skid_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_s2_q   <= pc_s2_d;
      pc4_s2_q  <= pc4_s2_d;
      inst_s2_q <= inst_s2_d;
      valid_q   <= valid_d;
      skid_q    <= skid_d;
    end
  end

endmodule
